// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
//
// Last stage of the RISC-V pipeline. It is also the write port of the
// register file. ALU results are written back on the cycle after they are
// accepted. Loads take a detour through a single memory read. The returned
// word is narrowed to a byte, a halfword or a word, extended to 32 bits, and
// then written back. No write ever reaches x0.
//
// Parameters
//   LOAD_OFF_W   width of the byte-offset field kept from the load address
//                (must be at least 2)
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   in_valid     execute stage presents a result
//   in_ready     unit can accept (high only in IDLE)
//   in_rd        destination register
//   in_result    ALU result, or effective address for loads
//   in_is_load   instruction is a LOAD
//   in_funct3    load width/sign code
//   in_wb        instruction writes rd
//   mem_req      one-cycle memory read request
//   mem_addr     word-aligned read address
//   mem_rvalid   read data valid
//   mem_rdata    read data word
//   w_en         register-file write enable (single-cycle pulse)
//   wd           register-file write address
//   wdata        register-file write data
// ---------------------------------------------------------------------------
module writeback_unit #(
   parameter int LOAD_OFF_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_result,
   input  logic        in_is_load,
   input  logic [2:0]  in_funct3,
   input  logic        in_wb,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        w_en,
   output logic [4:0]  wd,
   output logic [31:0] wdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [1:0]            state_q, state_d;
   logic [4:0]            loadRd_q, loadRd_d;
   logic [2:0]            loadFunct3_q, loadFunct3_d;
   logic [LOAD_OFF_W-1:0] loadOff_q, loadOff_d;
   logic [31:0]           memAddr_q, memAddr_d;
   logic                  wEn_q, wEn_d;
   logic [4:0]            wd_q, wd_d;
   logic [31:0]           wdata_q, wdata_d;

   logic [7:0]            loadByte;
   logic [15:0]           loadHalf;
   logic [31:0]           loadValue;

   // The handshake and the memory request depend only on the state. In REQ,
   // mem_req is high for exactly one cycle because REQ always moves on to
   // WAIT.
   assign in_ready = (state_q == IDLE);
   assign mem_req  = (state_q == REQ);
   assign mem_addr = memAddr_q;
   assign w_en     = wEn_q;
   assign wd       = wd_q;
   assign wdata    = wdata_q;

   // Load data extraction. The byte lane comes from the two low address
   // bits. For halfwords only the upper offset bit matters. Any funct3 that
   // is not one of the four narrow codes is treated as a full word load.
   always_comb begin
      loadByte  = mem_rdata[7:0];
      loadHalf  = loadOff_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      loadValue = mem_rdata;
      case (loadOff_q[1:0])
         2'd0:    loadByte = mem_rdata[7:0];
         2'd1:    loadByte = mem_rdata[15:8];
         2'd2:    loadByte = mem_rdata[23:16];
         default: loadByte = mem_rdata[31:24];
      endcase
      case (loadFunct3_q)
         F3_LB:   loadValue = {{24{loadByte[7]}}, loadByte};
         F3_LBU:  loadValue = {24'd0, loadByte};
         F3_LH:   loadValue = {{16{loadHalf[15]}}, loadHalf};
         F3_LHU:  loadValue = {16'd0, loadHalf};
         default: loadValue = mem_rdata;
      endcase
   end

   // Next-state logic. The write enable defaults to 0, so each write is a
   // one-cycle pulse. The write address and data default to holding their
   // values, so they keep the last write while the register file is idle.
   // Inputs are only examined in IDLE, and mem_rvalid only in WAIT.
   always_comb begin
      state_d      = state_q;
      loadRd_d     = loadRd_q;
      loadFunct3_d = loadFunct3_q;
      loadOff_d    = loadOff_q;
      memAddr_d    = memAddr_q;
      wEn_d        = 1'b0;
      wd_d         = wd_q;
      wdata_d      = wdata_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (in_is_load) begin
                  loadRd_d     = in_rd;
                  loadFunct3_d = in_funct3;
                  loadOff_d    = in_result[LOAD_OFF_W-1:0];
                  memAddr_d    = {in_result[31:2], 2'b00};
                  state_d      = REQ;
               end else if (in_wb && (in_rd != 5'd0)) begin
                  wEn_d   = 1'b1;
                  wd_d    = in_rd;
                  wdata_d = in_result;
               end
            end
         end
         REQ: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid) begin
               wEn_d   = (loadRd_q != 5'd0);
               wd_d    = loadRd_q;
               wdata_d = loadValue;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset returns to IDLE and drops any load in flight.
   // Because the FSM is back in IDLE, a late mem_rvalid cannot cause a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         loadRd_q     <= 5'd0;
         loadFunct3_q <= 3'd0;
         loadOff_q    <= '0;
         memAddr_q    <= 32'd0;
         wEn_q        <= 1'b0;
         wd_q         <= 5'd0;
         wdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         loadRd_q     <= loadRd_d;
         loadFunct3_q <= loadFunct3_d;
         loadOff_q    <= loadOff_d;
         memAddr_q    <= memAddr_d;
         wEn_q        <= wEn_d;
         wd_q         <= wd_d;
         wdata_q      <= wdata_d;
      end
   end

endmodule
